ram_responder: RTL and testbench

Main-memory model that sits on the RAM side of the cache's RAM port and answers the cache's read and write requests. It latches one request at a time, waits a programmable access latency, then commits the write or returns read data, and signals completion with a one-cycle acknowledge. It lets the cache miss/write-through path be exercised against realistic memory latency instead of an ideal zero-wait RAM.

---
 rtl/ram_responder.sv | 135 +++++++++++++
 tb/tb_ram_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Latency-modelling main-memory responder for the cache RAM port: one request at a time, ack after LATENCY+1 cycles.
// Optional RAM_RESPONDER_STATS_EN adds saturating committed-read/write counters.
module ram_responder #(
    parameter int WIDTH     = 8,
    parameter int RAM_DEPTH = 256,
    parameter int LATENCY   = 3,
    localparam int AW       = $clog2(RAM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             ack
`ifdef RAM_RESPONDER_STATS_EN
    ,
    output logic [15:0]      rd_count,
    output logic [15:0]      wr_count
`endif
);

    // state | meaning
    // IDLE  | waiting for req, request registers hold last request
    // WAIT  | latency down-counter running, access committed when cnt reaches 0
    // DONE  | ack cycle, new requests ignored
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] mem_q [RAM_DEPTH];
    logic             mem_we;
    logic             commit;

    assign commit = (state_q == WAIT) && (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        dout_d  = dout_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    data_d  = data_in;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (we_q) mem_we = 1'b1;
                    else      dout_d = mem_q[addr_q];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
        end
    end

    // Reset re-initialises every word to its own address, which makes read-back tests self-describing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_DEPTH; i++) mem_q[i] <= WIDTH'(i);
        end else if (mem_we) begin
            mem_q[addr_q] <= data_q;
        end
    end

    assign data_out = dout_q;
    assign busy     = (state_q != IDLE);
    assign ack      = (state_q == DONE);

`ifdef RAM_RESPONDER_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (commit && !we_q && rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
        if (commit &&  we_q && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: slot 0 runs LATENCY=3, slot 1 runs LATENCY=1.
// Expected ack cycle and data_out are queued at issue time and checked by a negedge monitor.
module tb_ram_responder;

    localparam int LAT [2] = '{3, 1};

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_v  [2];
    logic       req_v  [2];
    logic       we_v   [2];
    logic [7:0] addr_v [2];
    logic [7:0] din_v  [2];
    logic [7:0] dout_v [2];
    logic       busy_v [2];
    logic       ack_v  [2];
`ifdef RAM_RESPONDER_STATS_EN
    logic [15:0] rdc_v [2];
    logic [15:0] wrc_v [2];
`endif

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_responder #(.WIDTH(8), .RAM_DEPTH(256), .LATENCY(3)) u0 (
        .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .data_in(din_v[0]), .data_out(dout_v[0]), .busy(busy_v[0]), .ack(ack_v[0])
`ifdef RAM_RESPONDER_STATS_EN
        , .rd_count(rdc_v[0]), .wr_count(wrc_v[0])
`endif
    );

    ram_responder #(.WIDTH(8), .RAM_DEPTH(256), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .data_in(din_v[1]), .data_out(dout_v[1]), .busy(busy_v[1]), .ack(ack_v[1])
`ifdef RAM_RESPONDER_STATS_EN
        , .rd_count(rdc_v[1]), .wr_count(wrc_v[1])
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (ack_v[s]) begin
                exp_t e;
                int   sz;
                sz = (s == 0) ? q0.size() : q1.size();
                if (sz == 0) begin
                    check($sformatf("unexpected_ack_s%0d", s), 1, 0);
                end else begin
                    e = (s == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("ack_cycle_s%0d", s), cyc, e.cyc);
                    check($sformatf("data_out_s%0d", s), int'(dout_v[s]), int'(e.data));
                    check($sformatf("busy_at_ack_s%0d", s), int'(busy_v[s]), 1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int s, input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic expect_ack, input logic [7:0] e);
        exp_t x;
        req_v[s] = 1'b1; we_v[s] = w; addr_v[s] = a; din_v[s] = d;
        x.data = e;
        x.cyc  = cyc + LAT[s] + 1;
        if (expect_ack) begin
            if (s == 0) q0.push_back(x); else q1.push_back(x);
        end
        step();
        req_v[s] = 1'b0;
    endtask

    task automatic wait_idle(input int s);
        int sz;
        for (int i = 0; i < 40; i++) begin
            sz = (s == 0) ? q0.size() : q1.size();
            if (sz == 0) break;
            step();
        end
        sz = (s == 0) ? q0.size() : q1.size();
        if (sz != 0) begin
            check($sformatf("ack_timeout_s%0d", s), sz, 0);
            if (s == 0) q0.delete(); else q1.delete();
        end
    endtask

    task automatic do_reset(input int s);
        rst_v[s] = 1'b1;
        step();
        step();
        rst_v[s] = 1'b0;
    endtask

    initial begin
        int c;
        for (int s = 0; s < 2; s++) begin
            rst_v[s] = 1'b1; req_v[s] = 1'b0; we_v[s] = 1'b0; addr_v[s] = 8'h00; din_v[s] = 8'h00;
        end
        step();
        step();
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;

        check("reset_busy", int'(busy_v[0]), 0);
        check("reset_ack", int'(ack_v[0]), 0);
        check("reset_data_out", int'(dout_v[0]), 0);

        // Read after reset: busy in cycles 1..4, ack in cycle 4
        check("busy_cycle0", int'(busy_v[0]), 0);
        issue(0, 1'b0, 8'h2A, 8'h00, 1'b1, 8'h2A);
        for (int i = 2; i <= 6; i++) begin
            check($sformatf("busy_cycle%0d", i - 1), int'(busy_v[0]), (i - 1 <= 4) ? 1 : 0);
            step();
        end
        wait_idle(0);

        // Write then read-back in the cycle right after ack; write leaves data_out at 2A
        issue(0, 1'b1, 8'h10, 8'hA5, 1'b1, 8'h2A);
        wait_idle(0);
        issue(0, 1'b0, 8'h10, 8'h00, 1'b1, 8'hA5);
        wait_idle(0);

        // Requests while busy (cycles 2 and 4) are ignored
        c = cyc;
        issue(0, 1'b0, 8'h05, 8'h00, 1'b1, 8'h05);
        step();
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 8'h05; din_v[0] = 8'hFF;
        step();
        req_v[0] = 1'b0;
        step();
        req_v[0] = 1'b1;
        step();
        req_v[0] = 1'b0;
        check("busy_after_ignored", int'(busy_v[0]), 0);
        check("ignored_window_cycle", cyc - c, 5);
        repeat (6) step();
        issue(0, 1'b0, 8'h05, 8'h00, 1'b1, 8'h05);
        wait_idle(0);

        // rst and req in the same cycle: request dropped
        rst_v[0] = 1'b1; req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 8'h33;
        step();
        rst_v[0] = 1'b0; req_v[0] = 1'b0;
        check("rst_wins_busy", int'(busy_v[0]), 0);
        repeat (6) step();

        // Reset mid-write: no ack, busy low from cycle 3, memory restored
        issue(0, 1'b1, 8'h20, 8'h00, 1'b0, 8'h00);
        step();
        rst_v[0] = 1'b1;
        step();
        rst_v[0] = 1'b0;
        check("abort_busy_cycle3", int'(busy_v[0]), 0);
        check("abort_data_out", int'(dout_v[0]), 0);
        repeat (8) step();
        issue(0, 1'b0, 8'h20, 8'h00, 1'b1, 8'h20);
        wait_idle(0);

        // LATENCY=1 back-to-back reads: acks at cycles 2 and 5
        c = cyc;
        issue(1, 1'b0, 8'h01, 8'h00, 1'b1, 8'h01);
        wait_idle(1);
        check("lat1_second_issue_cycle", cyc - c, 3);
        issue(1, 1'b0, 8'hFE, 8'h00, 1'b1, 8'hFE);
        wait_idle(1);

`ifdef RAM_RESPONDER_STATS_EN
        do_reset(0);
        check("rd_count_reset", int'(rdc_v[0]), 0);
        check("wr_count_reset", int'(wrc_v[0]), 0);
        issue(0, 1'b0, 8'h01, 8'h00, 1'b1, 8'h01);
        wait_idle(0);
        issue(0, 1'b1, 8'h02, 8'hAA, 1'b1, 8'h01);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 8'h09; din_v[0] = 8'h99;
        step();
        req_v[0] = 1'b0;
        wait_idle(0);
        issue(0, 1'b1, 8'h03, 8'hBB, 1'b1, 8'h01);
        wait_idle(0);
        issue(0, 1'b0, 8'h02, 8'h00, 1'b1, 8'hAA);
        wait_idle(0);
        issue(0, 1'b0, 8'h03, 8'h00, 1'b1, 8'hBB);
        wait_idle(0);
        check("rd_count", int'(rdc_v[0]), 3);
        check("wr_count", int'(wrc_v[0]), 2);
        do_reset(0);
        check("rd_count_after_rst", int'(rdc_v[0]), 0);
        check("wr_count_after_rst", int'(wrc_v[0]), 0);
`endif

        repeat (4) step();
        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
